// File: rtl/vga_ctrl_pkg.sv
// Shared types and constants for the VGA input controller: mode enum,
// default geometry/repeat settings and coordinate widths.
package vga_ctrl_pkg;

  localparam int COLS_DEF          = 80;
  localparam int ROWS_DEF          = 60;
  localparam int REPEAT_FRAMES_DEF = 15;
  localparam int X_W               = 7;
  localparam int Y_W               = 6;
  localparam int NUM_BTN           = 5;

  typedef enum logic [1:0] {
    MODE_BARS    = 2'd0,
    MODE_CURSOR  = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_SOLID   = 2'd3
  } mode_t;

  function automatic mode_t next_mode(input mode_t m);
    mode_t n;
    case (m)
      MODE_BARS:    n = MODE_CURSOR;
      MODE_CURSOR:  n = MODE_CHECKER;
      MODE_CHECKER: n = MODE_SOLID;
      MODE_SOLID:   n = MODE_BARS;
      default:      n = MODE_BARS;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, stable-count debouncer and press pulse.
// The debounced level is exported only when VGA_CTRL_AUTOREPEAT_EN is defined.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
`ifdef VGA_CTRL_AUTOREPEAT_EN
  output logic level,
`endif
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          meta_r;
  logic          sync_r;
  logic          level_r;
  logic          level_d_r;
  logic          press_r;
  logic [CW-1:0] cnt_r;

  // Synchronise the raw input into the clock domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= raw;
      sync_r <= meta_r;
    end
  end

  // Accept a new level after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else if (sync_r != level_r) begin
      if (cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_r <= sync_r;
        cnt_r   <= {CW{1'b0}};
      end else begin
        cnt_r   <= cnt_r + CW'(1);
      end
    end else begin
      cnt_r <= {CW{1'b0}};
    end
  end

  // Rising-edge pulse of the debounced level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d_r <= 1'b0;
      press_r   <= 1'b0;
    end else begin
      level_d_r <= level_r;
      press_r   <= level_r & ~level_d_r;
    end
  end

  assign press = press_r;
`ifdef VGA_CTRL_AUTOREPEAT_EN
  assign level = level_r;
`endif

endmodule

// File: rtl/vga_input_ctrl.sv
// Button/switch front end for the VGA demo: working cursor, mode and colour,
// committed to the outputs on frame_start. Optional macro: VGA_CTRL_AUTOREPEAT_EN.
module vga_input_ctrl
  import vga_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int COLS            = COLS_DEF,
  parameter int ROWS            = ROWS_DEF,
  parameter int REPEAT_FRAMES   = REPEAT_FRAMES_DEF
) (
  input  logic           sysclk,
  input  logic           reset,
  input  logic           East,
  input  logic           West,
  input  logic           North,
  input  logic           South,
  input  logic           func_switch,
  input  logic           SW0,
  input  logic           SW1,
  input  logic           SW2,
  input  logic           SW3,
  input  logic           frame_start,
  output logic [X_W-1:0] cur_x,
  output logic [Y_W-1:0] cur_y,
  output logic [1:0]     mode,
  output logic [2:0]     colour,
  output logic           blank_en,
  output logic           cfg_valid
);

  // Bit order: 0 East, 1 West, 2 North, 3 South, 4 func_switch
  logic [NUM_BTN-1:0] raw_s;
  logic [NUM_BTN-1:0] press_s;
  logic [3:0]         move_s;
  logic [3:0]         sw_meta_r;
  logic [3:0]         sw_sync_r;
  logic [X_W-1:0]     x_r, x_next_s, cur_x_r;
  logic [Y_W-1:0]     y_r, y_next_s, cur_y_r;
  mode_t              mode_r, mode_next_s, mode_c_r;
  logic [2:0]         colour_r;
  logic               blank_r;
  logic               cfg_valid_r;

  assign raw_s = {func_switch, South, North, West, East};

`ifdef VGA_CTRL_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  logic [NUM_BTN-1:0] level_s;
  logic [3:0]         rep_r;
  logic [RW-1:0]      rep_cnt_r [4];
`endif

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk  (sysclk),
      .rst  (reset),
      .raw  (raw_s[i]),
`ifdef VGA_CTRL_AUTOREPEAT_EN
      .level(level_s[i]),
`endif
      .press(press_s[i])
    );
  end

`ifdef VGA_CTRL_AUTOREPEAT_EN
  // Per-direction frame counter; a held button re-fires every REPEAT_FRAMES frames
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rep_r <= 4'b0000;
      for (int i = 0; i < 4; i++) rep_cnt_r[i] <= {RW{1'b0}};
    end else begin
      for (int i = 0; i < 4; i++) begin
        rep_r[i] <= 1'b0;
        if (!level_s[i]) begin
          rep_cnt_r[i] <= {RW{1'b0}};
        end else if (frame_start) begin
          if (rep_cnt_r[i] == RW'(REPEAT_FRAMES - 1)) begin
            rep_cnt_r[i] <= {RW{1'b0}};
            rep_r[i]     <= 1'b1;
          end else begin
            rep_cnt_r[i] <= rep_cnt_r[i] + RW'(1);
          end
        end else begin
          rep_cnt_r[i] <= rep_cnt_r[i];
        end
      end
    end
  end

  assign move_s = press_s[3:0] | rep_r;
`else
  assign move_s = press_s[3:0];
`endif

  // Next working cursor and mode; opposing presses cancel
  always_comb begin
    x_next_s    = x_r;
    y_next_s    = y_r;
    mode_next_s = mode_r;
    case (move_s[1:0])
      2'b01:   x_next_s = (x_r == X_W'(COLS - 1)) ? {X_W{1'b0}} : x_r + X_W'(1);
      2'b10:   x_next_s = (x_r == {X_W{1'b0}}) ? X_W'(COLS - 1) : x_r - X_W'(1);
      default: x_next_s = x_r;
    endcase
    case (move_s[3:2])
      2'b10:   y_next_s = (y_r == Y_W'(ROWS - 1)) ? {Y_W{1'b0}} : y_r + Y_W'(1);
      2'b01:   y_next_s = (y_r == {Y_W{1'b0}}) ? Y_W'(ROWS - 1) : y_r - Y_W'(1);
      default: y_next_s = y_r;
    endcase
    if (press_s[4]) begin
      mode_next_s = next_mode(mode_r);
    end else begin
      mode_next_s = mode_r;
    end
  end

  // Working registers; switches are synchronised but not debounced
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      x_r       <= {X_W{1'b0}};
      y_r       <= {Y_W{1'b0}};
      mode_r    <= MODE_BARS;
      sw_meta_r <= 4'b0000;
      sw_sync_r <= 4'b0000;
    end else begin
      x_r       <= x_next_s;
      y_r       <= y_next_s;
      mode_r    <= mode_next_s;
      sw_meta_r <= {SW3, SW2, SW1, SW0};
      sw_sync_r <= sw_meta_r;
    end
  end

  // Commit on frame_start so the picture never changes mid-frame
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      cur_x_r     <= {X_W{1'b0}};
      cur_y_r     <= {Y_W{1'b0}};
      mode_c_r    <= MODE_BARS;
      colour_r    <= 3'b000;
      blank_r     <= 1'b0;
      cfg_valid_r <= 1'b0;
    end else begin
      cfg_valid_r <= frame_start;
      if (frame_start) begin
        cur_x_r  <= x_r;
        cur_y_r  <= y_r;
        mode_c_r <= mode_r;
        colour_r <= sw_sync_r[2:0];
        blank_r  <= sw_sync_r[3];
      end
    end
  end

  assign cur_x     = cur_x_r;
  assign cur_y     = cur_y_r;
  assign mode      = mode_c_r;
  assign colour    = colour_r;
  assign blank_en  = blank_r;
  assign cfg_valid = cfg_valid_r;

endmodule

// File: doc/vga_input_ctrl.md
VGA_INPUT_CTRL -- requirements
Module: vga_input_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning the consecutive stable cycles needed to accept a button level (10 ms at 50 MHz).
REQ-002 The block SHALL have parameter COLS, default 80, meaning the cursor column count.
REQ-003 The block SHALL have parameter ROWS, default 60, meaning the cursor row count.
REQ-004 The block SHALL have parameter REPEAT_FRAMES, default 15, meaning the auto-repeat period in frames.
REQ-005 The block SHALL have port sysclk, input, 1 bit: the 50 MHz system clock.
REQ-006 The block SHALL have port reset, input, 1 bit: the reset, asynchronous and active-high.
REQ-007 The block SHALL have ports East, West, North and South, each input, 1 bit: raw direction buttons, asynchronous, active-high.
REQ-008 The block SHALL have port func_switch, input, 1 bit: raw mode-change button, asynchronous, active-high.
REQ-009 The block SHALL have ports SW0, SW1, SW2 and SW3, each input, 1 bit: slide switches, asynchronous.
REQ-010 The block SHALL have port frame_start, input, 1 bit: one-cycle pulse from the VGA timing generator at the start of vertical blank.
REQ-011 The block SHALL have port cur_x, output, 7 bits: committed cursor column.
REQ-012 The block SHALL have port cur_y, output, 6 bits: committed cursor row.
REQ-013 The block SHALL have port mode, output, 2 bits: committed display mode.
REQ-014 The block SHALL have port colour, output, 3 bits ({R,G,B}): committed foreground colour.
REQ-015 The block SHALL have port blank_en, output, 1 bit: committed forced-blank.
REQ-016 The block SHALL have port cfg_valid, output, 1 bit: one-cycle pulse after every commit.

Function
REQ-017 The block SHALL pass every button and switch through a 2-flop synchroniser on sysclk.
REQ-018 The block SHALL change a debounced button level only after the synchronised input has differed from it for exactly DEBOUNCE_CYCLES consecutive cycles; any bounce SHALL restart the count.
REQ-019 The block SHALL generate a one-cycle press pulse on the cycle after each debounced 0->1 transition; releases SHALL generate no pulse.
REQ-020 The block SHALL update its working registers on the cycle after a press pulse.
REQ-021 A press on East SHALL increment working x, wrapping from COLS-1 to 0; a press on West SHALL decrement it, wrapping from 0 to COLS-1.
REQ-022 A press on South SHALL increment working y and a press on North SHALL decrement it, with the same wrap rules against ROWS.
REQ-023 Simultaneous East+West press pulses SHALL leave x unchanged, and simultaneous North+South press pulses SHALL leave y unchanged.
REQ-024 Mode FSM states SHALL be MODE_BARS(0), MODE_CURSOR(1), MODE_CHECKER(2) and MODE_SOLID(3), advancing BARS->CURSOR->CHECKER->SOLID->BARS on each func_switch press pulse and holding otherwise.
REQ-025 Working colour SHALL track {SW2,SW1,SW0} and working blank SHALL track SW3, with no debounce applied.
REQ-026 On a frame_start pulse, all outputs except cfg_valid SHALL load from the working registers on the next edge, and cfg_valid SHALL be 1 for that one cycle.
REQ-027 Between commits, outputs SHALL hold, so no tearing occurs mid-frame.
REQ-028 A press pulse coinciding with frame_start SHALL take effect at the following commit, not the current one.
REQ-029 Multiple presses within one frame SHALL all accumulate in the working registers.

Reset
REQ-030 Asserting reset SHALL immediately clear all synchronisers, debounce counters, debounced levels, working and committed registers.
REQ-031 During reset, outputs SHALL be cur_x=0, cur_y=0, mode=MODE_BARS, colour=0, blank_en=0 and cfg_valid=0.
REQ-032 A button held through reset release SHALL be debounced as a new press (DEBOUNCE_CYCLES after release, plus synchroniser delay).

Configuration
REQ-033 With VGA_CTRL_AUTOREPEAT_EN defined, a direction button held debounced-high SHALL generate an extra press pulse on every REPEAT_FRAMES-th frame_start after its initial press, with the repeat counter cleared on release.
REQ-034 Without VGA_CTRL_AUTOREPEAT_EN, holding a button SHALL produce exactly one move and no repeat logic SHALL exist; func_switch SHALL never auto-repeat.

Structure
REQ-035 Package vga_ctrl_pkg SHALL hold the mode enum type, default COLS, ROWS and REPEAT_FRAMES constants, and coordinate widths.
REQ-036 Sub-module btn_debounce (synchroniser, counter and edge pulse) SHALL be instantiated five times.

Verification (DEBOUNCE_CYCLES=4, COLS=80, ROWS=60)
REQ-037 Reset, hold East high for 10 cycles, then pulse frame_start -> cur_x=1 and cfg_valid high one cycle after frame_start; no change before frame_start.
REQ-038 West press from x=0, then frame_start -> cur_x=79; North press from y=0 -> cur_y=59.
REQ-039 East toggling every 2 cycles for 20 cycles, then stable low -> no x change; East and West pressed in the same cycle -> x unchanged.
REQ-040 Four func_switch presses separated by frame_start pulses -> mode sequence 1,2,3,0.
REQ-041 SW={SW3..SW0}=4'b1101, then frame_start -> colour=3'b101 and blank_en=1; assert reset mid-debounce -> all outputs zero immediately.
REQ-042 With VGA_CTRL_AUTOREPEAT_EN and REPEAT_FRAMES=2, East held across 6 frame_start pulses -> cur_x reaches 4.
